// File: rtl/dma_timing_control_if.sv
// Bus-side signals of the DMA timing/control stage: CPU hold handshake,
// address enables, read/write strobes, READY and the EOP pair.
interface dma_timing_control_if;
  // HRQ rises when the controller wants the bus and stays high until it has returned to idle.
  // No bus cycle starts until HLDA is seen high while HRQ is high, and HLDA dropping after that is ignored.
  // READY low while a strobe is active stretches the transfer, one wait cycle per low sample.
  logic HRQ;
  logic HLDA;
  logic AEN;
  logic ADSTB;
  logic MEMR_N;
  logic MEMW_N;
  logic IOR_N;
  logic IOW_N;
  logic READY;
  logic EOP_IN_N;
  logic EOP_OUT_N;

  modport master (
    output HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_OUT_N,
    input  HLDA, READY, EOP_IN_N
  );

  modport slave (
    input  HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_OUT_N,
    output HLDA, READY, EOP_IN_N
  );
endinterface

// File: rtl/dma_timing_control.sv
// 8237A-style DMA timing/control: hold handshake, S0-S4 sequencing, strobes, TC/EOP.
// Optional compressed timing is built when DMA_COMPRESSED_TIMING_EN is defined.
module dma_timing_control #(
  parameter int COUNT_W = 16,
  parameter int NUM_CH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dma_timing_control_if.master  bus,
  input  logic [NUM_CH-1:0]     grant,
  input  logic [NUM_CH-1:0]     dreq_valid,
  input  logic [7:0]            cmd_reg,
  input  logic [6*NUM_CH-1:0]   mode_regs,
  input  logic [COUNT_W-1:0]    cur_count,
  output logic [NUM_CH-1:0]     dack_en,
  output logic [1:0]            active_ch,
  output logic                  cnt_dec,
  output logic [NUM_CH-1:0]     tc,
  output logic [2:0]            dbgState
);

  typedef enum logic [2:0] {
    SI = 3'd0, S0 = 3'd1, S1 = 3'd2, S2 = 3'd3, S3 = 3'd4, SW = 3'd5, S4 = 3'd6
  } dmaState_e;

  dmaState_e state, nextState, contState;
  logic [1:0] grantIdx;
  logic [5:0] modeCh;
  logic [1:0] xferType, xferMode;
  logic       compressed, terminate, eopLatch, unusedBits;
  logic       hrqNxt, aenNxt, adstbNxt, cntDecNxt, eopOutNxt;
  logic       memrNxt, memwNxt, iorNxt, iowNxt, readPhase, writePhase;
  logic [NUM_CH-1:0] dackNxt, tcNxt;

  assign modeCh    = mode_regs[6*active_ch +: 6];
  assign xferType  = modeCh[1:0];
  assign xferMode  = modeCh[5:4];
  // A zero count at S4 means this transfer wraps the counter: it is the last one.
  assign terminate = (cur_count == '0) || eopLatch;
  assign dbgState  = state;

`ifdef DMA_COMPRESSED_TIMING_EN
  assign compressed = cmd_reg[3];
  assign contState  = (compressed && cur_count[7:0] != 8'd0) ? S2 : S1;
  assign unusedBits = ^{cmd_reg[7:4], cmd_reg[1:0], modeCh[3:2]};
`else
  assign compressed = 1'b0;
  assign contState  = S1;
  assign unusedBits = ^{cmd_reg[7:3], cmd_reg[1:0], modeCh[3:2]};
`endif

  always_comb begin
    grantIdx = 2'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grantIdx = 2'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= SI;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      SI: if (!cmd_reg[2] && grant != '0) nextState = S0;
      S0: begin
        if (grant == '0)   nextState = SI;
        else if (bus.HLDA) nextState = S1;
      end
      S1: nextState = S2;
      S2: begin
        if (compressed) nextState = bus.READY ? S4 : SW;
        else            nextState = S3;
      end
      S3: nextState = bus.READY ? S4 : SW;
      SW: if (bus.READY) nextState = S4;
      S4: begin
        if (terminate)              nextState = SI;
        else if (xferMode == 2'b10) nextState = contState;
        else if (xferMode == 2'b00) nextState = dreq_valid[active_ch] ? contState : SI;
        else                        nextState = SI;
      end
      default: nextState = SI;
    endcase
  end

  always_comb begin
    readPhase  = state inside {S2, S3, SW};
    writePhase = (state inside {S3, SW}) || (state == S2 && compressed);
    hrqNxt     = state != SI;
    aenNxt     = state inside {S1, S2, S3, SW, S4};
    adstbNxt   = state == S1;
    dackNxt    = (state inside {S2, S3, SW, S4}) ? (NUM_CH'(1) << active_ch) : '0;
    memrNxt    = !(readPhase  && xferType == 2'b10);
    iorNxt     = !(readPhase  && xferType == 2'b01);
    iowNxt     = !(writePhase && xferType == 2'b10);
    memwNxt    = !(writePhase && xferType == 2'b01);
    cntDecNxt  = state == S4;
    tcNxt      = (state == S4 && terminate) ? (NUM_CH'(1) << active_ch) : '0;
    eopOutNxt  = !(state == S4 && terminate);
  end

  // Channel is captured only on the S0->S1 step; EOP is remembered until S4 consumes it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_ch <= 2'd0;
      eopLatch  <= 1'b0;
    end else begin
      if (state == S0 && bus.HLDA && grant != '0) active_ch <= grantIdx;
      if (state == S4) eopLatch <= 1'b0;
      else if (state inside {S1, S2, S3, SW} && !bus.EOP_IN_N) eopLatch <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.HRQ       <= 1'b0;
      bus.AEN       <= 1'b0;
      bus.ADSTB     <= 1'b0;
      bus.MEMR_N    <= 1'b1;
      bus.MEMW_N    <= 1'b1;
      bus.IOR_N     <= 1'b1;
      bus.IOW_N     <= 1'b1;
      bus.EOP_OUT_N <= 1'b1;
      dack_en       <= '0;
      cnt_dec       <= 1'b0;
      tc            <= '0;
    end else begin
      bus.HRQ       <= hrqNxt;
      bus.AEN       <= aenNxt;
      bus.ADSTB     <= adstbNxt;
      bus.MEMR_N    <= memrNxt;
      bus.MEMW_N    <= memwNxt;
      bus.IOR_N     <= iorNxt;
      bus.IOW_N     <= iowNxt;
      bus.EOP_OUT_N <= eopOutNxt;
      dack_en       <= dackNxt;
      cnt_dec       <= cntDecNxt;
      tc            <= tcNxt;
    end
  end

endmodule

// File: tb/tb_dma_timing_control.sv
// Bench for dma_timing_control: a cycle plan of intended bus phases is generated from
// transfer-level parameters, expected outputs are derived from it, then replayed on the DUT.
`timescale 1ns/1ps
module tb_dma_timing_control;
  localparam int PSI = 0, PS0 = 1, PS1 = 2, PS2 = 3, PS3 = 4, PSW = 5, PS4 = 6;
`ifdef DMA_COMPRESSED_TIMING_EN
  localparam bit compEn = 1'b1;
`else
  localparam bit compEn = 1'b0;
`endif

  typedef struct packed {
    int          ph;
    logic        rst;
    logic [3:0]  grant;
    logic [3:0]  dreq;
    logic        hlda;
    logic        ready;
    logic        eopN;
    logic [15:0] cnt;
    logic [7:0]  cmd;
    logic [23:0] mode;
    logic        term;
    logic [1:0]  ch;
    logic [1:0]  tt;
  } cyc_t;

  logic        CLK, RESET;
  logic [3:0]  grant, dreq_valid, dack_en, tc;
  logic [7:0]  cmd_reg;
  logic [23:0] mode_regs;
  logic [15:0] cur_count;
  logic [1:0]  active_ch;
  logic        cnt_dec;
  logic [2:0]  dbgState;

  dma_timing_control_if busIf();

  dma_timing_control #(.COUNT_W(16), .NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(busIf),
    .grant(grant), .dreq_valid(dreq_valid), .cmd_reg(cmd_reg), .mode_regs(mode_regs),
    .cur_count(cur_count), .dack_en(dack_en), .active_ch(active_ch),
    .cnt_dec(cnt_dec), .tc(tc), .dbgState(dbgState)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  cyc_t        plan[$];
  logic [18:0] exp_q[$];
  logic [7:0]  cmdCur;
  logic [23:0] modeCur;
  int          numChecks = 0;
  int          numErrors = 0;

  task automatic checkVal(input string tag, input logic [18:0] got, input logic [18:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction
  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  task automatic addCyc(input int ph, input logic rst, input logic [3:0] g, input logic hl,
                        input logic rdy, input logic eopN, input logic [3:0] dq,
                        input logic [15:0] cnt, input logic term, input logic [1:0] ch,
                        input logic [1:0] tt);
    cyc_t c;
    c.ph = ph; c.rst = rst; c.grant = g; c.dreq = dq; c.hlda = hl; c.ready = rdy;
    c.eopN = eopN; c.cnt = cnt; c.cmd = cmdCur; c.mode = modeCur; c.term = term;
    c.ch = ch; c.tt = tt;
    plan.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) addCyc(PSI, 0, 4'b0, rb(), rb(), rb(), r4(), r16(), 0, 2'd0, 2'd0);
  endtask

  // One serviced request: hold handshake, then transfers until the mode/TC/EOP rules end it.
  task automatic service(input int ch, input int tt, input int md, input int startCnt,
                         input int hldaDly, input int waitFix, input int dropAt,
                         input int eopAt, input int rstAt, input int tail);
    logic [3:0] g, dq;
    logic [1:0] c2, t2;
    logic [15:0] c16;
    int  cnt, k, w;
    bit  done, comp, skipS1, cont, eopHere, term, dqCh;
    c2 = 2'(ch); t2 = 2'(tt); g = 4'b0001 << c2;
    cmdCur = 8'($urandom) & 8'hFB;
    modeCur = 24'($urandom);
    modeCur[ch*6 +: 6] = {2'(md), 2'($urandom_range(0, 3)), t2};
    comp = compEn && cmdCur[3];
    cnt = startCnt; k = 0; done = 0; skipS1 = 0;
    addCyc(PSI, 0, g, rb(), rb(), rb(), r4(), r16(), 0, c2, t2);
    for (int i = 0; i < hldaDly; i++) addCyc(PS0, 0, g, 0, rb(), rb(), r4(), r16(), 0, c2, t2);
    addCyc(PS0, 0, g, 1, rb(), rb(), r4(), r16(), 0, c2, t2);
    while (!done) begin
      c16 = 16'(cnt);
      eopHere = (k == eopAt);
      w = (waitFix >= 0) ? waitFix : int'($urandom_range(0, 2));
      if (k == rstAt && w == 0) w = 1;
      if (!skipS1) addCyc(PS1, 0, r4(), rb(), rb(), 1'b1, r4(), r16(), 0, c2, t2);
      if (comp) begin
        addCyc(PS2, 0, r4(), rb(), w == 0, !eopHere, r4(), r16(), 0, c2, t2);
      end else begin
        addCyc(PS2, 0, r4(), rb(), rb(), !eopHere, r4(), r16(), 0, c2, t2);
        addCyc(PS3, 0, r4(), rb(), w == 0, 1'b1, r4(), r16(), 0, c2, t2);
      end
      if (k == rstAt) begin
        addCyc(PSW, 1, r4(), rb(), 1'b0, 1'b1, r4(), r16(), 0, c2, t2);
        idle(tail + 1);
        return;
      end
      for (int i = 0; i < w; i++) addCyc(PSW, 0, r4(), rb(), i == w - 1, 1'b1, r4(), r16(), 0, c2, t2);
      term = (c16 == 16'd0) || eopHere;
      dqCh = (md == 0) ? (k != dropAt) : rb();
      dq = r4(); dq[c2] = dqCh;
      addCyc(PS4, 0, r4(), rb(), rb(), rb(), dq, c16, term, c2, t2);
      if (term)         cont = 0;
      else if (md == 2) cont = 1;
      else if (md == 0) cont = dqCh;
      else              cont = 0;
      if (cont) begin
        skipS1 = comp && (c16[7:0] != 8'd0);
        cnt = cnt - 1;
        k++;
      end else begin
        done = 1;
      end
    end
    idle(tail);
  endtask

  // Outputs seen after the edge that ends cycle p: a registered image of p's phase.
  function automatic logic [18:0] expOf(input cyc_t p, input logic [1:0] ach);
    logic hrq, aen, adstb, rd, wr, memr, memw, ior, iow, cd, eo, comp;
    logic [3:0] dk, tcv;
    if (p.rst) return {3'b000, 4'b0000, 2'b00, 4'b1111, 1'b0, 4'b0000, 1'b1};
    comp  = compEn && p.cmd[3];
    hrq   = p.ph != PSI;
    aen   = p.ph inside {PS1, PS2, PS3, PSW, PS4};
    adstb = p.ph == PS1;
    dk    = (p.ph inside {PS2, PS3, PSW, PS4}) ? (4'b0001 << p.ch) : 4'b0000;
    rd    = p.ph inside {PS2, PS3, PSW};
    wr    = (p.ph inside {PS3, PSW}) || (p.ph == PS2 && comp);
    memr  = !(rd && p.tt == 2'b10);
    ior   = !(rd && p.tt == 2'b01);
    iow   = !(wr && p.tt == 2'b10);
    memw  = !(wr && p.tt == 2'b01);
    cd    = p.ph == PS4;
    tcv   = p.term ? (4'b0001 << p.ch) : 4'b0000;
    eo    = !p.term;
    return {hrq, aen, adstb, dk, ach, memr, memw, ior, iow, cd, tcv, eo};
  endfunction

  function automatic logic [1:0] oneHotIdx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic driveCyc(input cyc_t c);
    RESET          = c.rst;
    grant          = c.grant;
    dreq_valid     = c.dreq;
    cmd_reg        = c.cmd;
    mode_regs      = c.mode;
    cur_count      = c.cnt;
    busIf.HLDA     = c.hlda;
    busIf.READY    = c.ready;
    busIf.EOP_IN_N = c.eopN;
  endtask

  initial begin
    logic [1:0] ach;
    logic [3:0] g;
    int md, dropAt, cnt;
    cmdCur = 8'h00; modeCur = 24'h0;
    addCyc(PSI, 1, 4'b0, 0, 1, 1, 4'b0, 16'd0, 0, 2'd0, 2'd0);
    addCyc(PSI, 1, 4'b0, 0, 1, 1, 4'b0, 16'd0, 0, 2'd0, 2'd0);
    idle(2);
    // ch  tt md  cnt hlda wait drop eop rst tail
    service(2, 2, 1,   5, 3,  0,  -1, -1, -1, 2);   // single read ch2
    service(0, 1, 2,   2, 1,  0,  -1, -1, -1, 2);   // block write ch0, TC on third
    service(1, 2, 1,   4, 0,  2,  -1, -1, -1, 2);   // two wait states
    service(3, 2, 0, 100, 0, -1,   1, -1, -1, 2);   // demand, dreq drops in second
    service(1, 1, 2,  50, 0, -1,  -1,  1, -1, 2);   // external EOP in block mode
    service(3, 2, 2,   0, 0, -1,  -1,  0, -1, 1);   // TC and EOP together
    service(2, 2, 2,  10, 0,  2,  -1, -1,  1, 2);   // reset in SW
    service(0, 3, 3,   7, 1, -1,  -1, -1, -1, 0);   // illegal codes, immediate re-request
    service(0, 0, 1,   7, 0, -1,  -1, -1, -1, 2);
    cmdCur = 8'h00; g = 4'b0010;
    addCyc(PSI, 0, g, 0, 1, 1, r4(), r16(), 0, 2'd1, 2'd0);
    addCyc(PS0, 0, g, 0, 1, 1, r4(), r16(), 0, 2'd1, 2'd0);
    addCyc(PS0, 0, g, 0, 1, 1, r4(), r16(), 0, 2'd1, 2'd0);
    addCyc(PS0, 0, 4'b0, 0, 1, 1, r4(), r16(), 0, 2'd1, 2'd0);
    idle(2);
    cmdCur = 8'h04;
    for (int i = 0; i < 3; i++) addCyc(PSI, 0, 4'b1000, rb(), rb(), rb(), r4(), r16(), 0, 2'd3, 2'd0);
    cmdCur = 8'h00;
    idle(1);
    for (int n = 0; n < 30; n++) begin
      md = $urandom_range(0, 3);
      dropAt = (md == 0) ? int'($urandom_range(0, 3)) : -1;
      cnt = (md == 0 && $urandom_range(0, 1) == 1) ? 200 : int'($urandom_range(0, 3));
      service($urandom_range(0, 3), $urandom_range(0, 3), md, cnt, $urandom_range(0, 3), -1,
              dropAt, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1,
              $urandom_range(0, 2));
    end
    idle(3);

    ach = 2'd0;
    foreach (plan[t]) begin
      if (plan[t].rst) ach = 2'd0;
      else if (plan[t].ph == PS0 && plan[t].hlda && plan[t].grant != 4'b0) ach = oneHotIdx(plan[t].grant);
      exp_q.push_back(expOf(plan[t], ach));
    end

    for (int t = 0; t < plan.size(); t++) begin
      driveCyc(plan[t]);
      @(posedge CLK);
      #1;
      checkVal($sformatf("cyc%0d", t),
               {busIf.HRQ, busIf.AEN, busIf.ADSTB, dack_en, active_ch, busIf.MEMR_N,
                busIf.MEMW_N, busIf.IOR_N, busIf.IOW_N, cnt_dec, tc, busIf.EOP_OUT_N},
               exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
